// File: rtl/mse_window_accum.sv
// Scores an approximate FIR against the exact FIR over 2^LOG2N valid samples: SSE, MSE, max |err|, mismatch count.
// Three-stage pipeline; results and done are registered 3 edges after the last sample is accepted. There is no backpressure.
module mse_window_accum #(
  parameter int W     = 16,
  parameter int LOG2N = 10,
  localparam int ACC_W = 2*(W+1)+LOG2N
) (
  input  logic                  clk,
  input  logic                  rstN,
  input  logic                  start,
  input  logic                  in_valid,
  input  logic signed [W-1:0]   y_ref,
  input  logic signed [W-1:0]   y_apx,
  output logic                  busy,
  output logic                  done,
  output logic [ACC_W-1:0]      sse,
  output logic [2*(W+1)-1:0]    mse,
  output logic [W:0]            max_abs_err,
  output logic [LOG2N:0]        err_count
);

  localparam int SW  = W + 1;
  localparam int SQW = 2 * SW;

  typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, DONE} state_t;

  state_t             state_q;
  logic [LOG2N-1:0]   smp_cnt_q;
  logic               s1_vld_q, s2_vld_q, s2_nz_q;
  logic [SW-1:0]      s1_a_q, s2_a_q;
  logic [SQW-1:0]     s2_sq_q;
  logic [ACC_W-1:0]   acc_q, sse_q;
  logic [SW-1:0]      maxr_q, max_q;
  logic [LOG2N:0]     cnt_q, errc_q;
  logic               busy_q, done_q;

  logic [SW-1:0]      diff_d, abs_d;
  logic [SQW-1:0]     sq_d;
  logic               accept, restart;

  // One extra bit of width makes the difference exact, so |d| never overflows.
  assign diff_d  = {y_ref[W-1], y_ref} - {y_apx[W-1], y_apx};
  assign abs_d   = diff_d[SW-1] ? (~diff_d + 1'b1) : diff_d;
  assign sq_d    = SQW'(s1_a_q) * SQW'(s1_a_q);
  assign accept  = (state_q == ACCUM) && in_valid;
  assign restart = start && ((state_q == IDLE) || (state_q == DONE));

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state_q   <= IDLE;
      smp_cnt_q <= '0;
      s1_vld_q  <= 1'b0;
      s1_a_q    <= '0;
      s2_vld_q  <= 1'b0;
      s2_a_q    <= '0;
      s2_sq_q   <= '0;
      s2_nz_q   <= 1'b0;
      acc_q     <= '0;
      maxr_q    <= '0;
      cnt_q     <= '0;
      sse_q     <= '0;
      max_q     <= '0;
      errc_q    <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      s1_vld_q <= accept;
      if (accept) s1_a_q <= abs_d;

      s2_vld_q <= s1_vld_q;
      if (s1_vld_q) begin
        s2_a_q  <= s1_a_q;
        s2_sq_q <= sq_d;
        s2_nz_q <= |s1_a_q;
      end

      if (s2_vld_q) begin
        acc_q  <= acc_q + ACC_W'(s2_sq_q);
        maxr_q <= (s2_a_q > maxr_q) ? s2_a_q : maxr_q;
        cnt_q  <= cnt_q + (LOG2N+1)'(s2_nz_q);
      end

      case (state_q)
        IDLE, DONE: begin
          done_q <= 1'b0;
          if (restart) begin
            state_q   <= ACCUM;
            busy_q    <= 1'b1;
            smp_cnt_q <= '0;
            acc_q     <= '0;
            maxr_q    <= '0;
            cnt_q     <= '0;
            s1_vld_q  <= 1'b0;
            s2_vld_q  <= 1'b0;
          end else begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        ACCUM: begin
          if (accept) begin
            smp_cnt_q <= smp_cnt_q + 1'b1;
            if (smp_cnt_q == '1) state_q <= DRAIN;
          end
        end
        DRAIN: begin
          // Both pipeline stages empty means the last sample has reached the accumulators.
          if (!s1_vld_q && !s2_vld_q) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            sse_q   <= acc_q;
            max_q   <= maxr_q;
            errc_q  <= cnt_q;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign sse         = sse_q;
  assign mse         = sse_q[ACC_W-1:LOG2N];
  assign max_abs_err = max_q;
  assign err_count   = errc_q;

endmodule

// File: doc/mse_window_accum.md
Name: mse_window_accum

Overview:
- Streaming error-metric stage that sits directly downstream of the 3-tap FIR (Fir3Tap) in the MSE measurement flow.
- Consumes the approximate-adder FIR output alongside the exact-FIR output, sample by sample.
- Over a window of 2^LOG2N valid samples, accumulates the squared error, maximum absolute error and count of mismatching samples, then reports MSE.
- Lets approximate-adder variants be scored in RTL/gate-level simulation without post-processing output text files.

Parameters:
W, 16, sample width of both signed FIR outputs
LOG2N, 10, log2 of window length N (N = 2^LOG2N samples)
ACC_W, 2*(W+1)+LOG2N, sum-of-squared-error accumulator width (derived, not overridden)

Ports:
clk  in  1  system clock, all state on rising edge
rstN  in  1  asynchronous active-low reset
start  in  1  request new measurement window
in_valid  in  1  y_ref/y_apx carry a valid sample this cycle
y_ref  in  W  signed output of exact FIR
y_apx  in  W  signed output of approximate FIR
busy  out  1  high from window start until done
done  out  1  one-cycle pulse: results updated
sse  out  ACC_W  unsigned sum of squared errors, held
mse  out  2*(W+1)  unsigned sse >> LOG2N (floor), held
max_abs_err  out  W+1  unsigned max |y_ref - y_apx| in window, held
err_count  out  LOG2N+1  samples with y_ref != y_apx, held

Behaviour:
- Reset (rstN low, async): FSM = IDLE, all pipeline valids 0, accumulators 0, sample counter 0. Outputs busy=0, done=0, sse=0, mse=0, max_abs_err=0, err_count=0.
- FSM states: IDLE, ACCUM, DRAIN, DONE.
  - IDLE: start=1 -> ACCUM. Clears accumulators, sample counter and pipeline valids on that edge. Held outputs are not cleared.
  - ACCUM: each edge with in_valid=1 accepts one sample into stage 1 and increments the counter. On the edge accepting sample N -> DRAIN. in_valid=0 cycles are bubbles and are not counted. start is ignored.
  - DRAIN: in_valid ignored. Waits until the last sample has passed stage 3 (2 edges after acceptance) -> DONE.
  - DONE: lasts exactly one cycle, then -> IDLE. start=1 in the DONE cycle behaves as in IDLE: next state is ACCUM, with a clean restart.
- busy = 1 in ACCUM and DRAIN, 0 otherwise. done = 1 only in DONE.
- Pipeline (per accepted sample):
  - Stage 1 register: d = sext(y_ref) - sext(y_apx) in W+1 bits signed; a = |d| in W+1 bits unsigned (no overflow: |d| <= 2^(W+1)-1).
  - Stage 2 register: sq = a*a in 2*(W+1) bits unsigned; nz = (a != 0).
  - Stage 3: acc += sq (ACC_W bits, cannot overflow for N samples); maxr = max(maxr, a); cnt += nz.
- Latency: if sample N is accepted at edge E, stage-3 update happens at E+2, and the results and done are registered at E+3. Thus done is high E+3..E+4 and busy falls at E+3.
- Held outputs (sse, mse, max_abs_err, err_count) change only on entry to DONE. They are stable through subsequent IDLE/ACCUM until the next DONE.
- Samples presented with in_valid=1 outside ACCUM have no effect.
- Reset mid-window aborts immediately. No partial result is reported.
- Ties in max: value unchanged. Sign of the error is irrelevant to every output.

Test Plan:
- Default params, y_ref=y_apx varied over 1024 samples -> done once; sse=0, mse=0, max_abs_err=0, err_count=0.
- LOG2N=2; ref={10,20,-5,0}, apx={8,20,-9,3}, continuous valid -> sse=29, mse=7, max_abs_err=4, err_count=3. done exactly 3 edges after the 4th sample is accepted.
- LOG2N=2; ref=32767, apx=-32768 for all four -> per-sample sq=4294836225, sse=17179344900, mse=4294836225, max_abs_err=65535, err_count=4 (no wrap).
- LOG2N=2; same data as case 2 with in_valid pattern 1,0,0,1,1,0,1, then extra valid samples during DRAIN -> identical results; extra samples ignored.
- start pulsed during ACCUM -> ignored, window completes normally. start asserted in the DONE cycle -> busy high next cycle and second window results independent of the first.
- rstN dropped after 2 of 4 samples -> all outputs 0 asynchronously, busy=0, no done. A new start then yields correct case-2 results.
